vgalcd_fetch: RTL and testbench
===============================

// Module: vgalcd_fetch
// PURPOSE
// Framebuffer fetch stage directly upstream of the vgalcd core pixel port.
// Issues single-beat 64-bit reads from base_addr_i on a req/gnt/rvalid bus and buffers the returned words in a FWFT FIFO.
// Presents FIFO data on the valid/ready pixel port (4 x 16bpp pixels per word).
// Restarts at the framebuffer base on every frame boundary (vend from the timing generator).
// PARAMETERS
// FIFO_DEPTH   16  FIFO entries of 64 bits; power of 2, >=4.
// ADDR_WIDTH   32  memory address width.
// PORTS
// clk_i          in   1                   system clock
// rst_n_i        in   1                   async active-low reset
// en_i           in   1                   fetch enable; 0 = flush and go idle
// base_addr_i    in   ADDR_WIDTH          framebuffer base; 8-byte aligned
// hvlen_i        in   `VGALCD_VB_WIDTH    active pixels per line; multiple of 4
// vvlen_i        in   `VGALCD_VB_WIDTH    active lines per frame
// frame_start_i  in   1                   one-cycle pulse (core vend_o) = restart
// mem_req_o      out  1                   read request
// mem_addr_o     out  ADDR_WIDTH          read address; held while req && !gnt
// mem_gnt_i      in   1                   request accepted
// mem_rvalid_i   in   1                   read data valid; in-order, 1 per grant
// mem_rdata_i    in   64                  read data
// pixel_valid_o  out  1                   FIFO not empty, and not dropping
// pixel_ready_i  in   1                   core pixel_ready_o
// pixel_data_o   out  64                  FIFO head (FWFT); pixel0 = [15:0]
// level_o        out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
// underflow_o    out  1                   sticky underflow flag
// BEHAVIOUR
// - Reset values of all outputs: 0, including FIFO, counters and FSM = IDLE.
// - FSM states: IDLE, FETCH, DONE.
//   - IDLE -> FETCH on frame_start_i && en_i.
//   - FETCH -> DONE when the issued-word count reaches frame_words.
//   - DONE -> FETCH on frame_start_i.
//   - Any state -> IDLE when !en_i.
// - Restart: at frame_start_i, latch frame_words = (hvlen_i*vvlen_i)>>2 (32-bit product).
//   Also at frame_start_i: addr = base_addr_i, issued count = 0, FIFO flushed.
// - Credit: assert mem_req_o in FETCH only when level + outstanding < FIFO_DEPTH. The FIFO therefore never overflows.
// - outstanding: +1 on req&&gnt, -1 on rvalid; both in the same cycle = unchanged.
// - Address: after each grant, addr += 8; it wraps modulo 2^ADDR_WIDTH.
// - Mid-flight restart or disable: latch drop = outstanding (including a grant in the same cycle).
//   - The next drop rvalid beats are discarded, not written to the FIFO.
//   - pixel_valid_o = 0 while drop != 0.
//   - New requests may issue during drop; credit counts drop beats as outstanding.
// - FIFO:
//   - Write on rvalid && drop==0.
//   - Read on pixel_valid_o && pixel_ready_i.
//   - Simultaneous read and write on full or empty is legal; level is unchanged.
//   - Read data has zero latency: head is visible the same cycle valid rises.
//   - The core samples [15:0] combinationally.
// - No combinational path from pixel_ready_i to mem_req_o.
// - frame_words==0: FETCH goes straight to DONE with no requests.
// - frame_start_i while !en_i is ignored.
// CONFIGURATION
// VGALCD_FETCH_UNDERFLOW_EN
// - Defined:
//   - underflow_o sets when pixel_ready_i && !pixel_valid_o && state==FETCH && issued>0.
//   - It clears on the next frame_start_i or on !en_i.
//   - A 16-bit saturating underflow counter is readable on hierarchical signal s_ufl_cnt_q.
// - Undefined: underflow_o tied to 0; no counter logic.
// TESTING
// - hvlen=8, vvlen=2, base=0x1000, gnt=1, rvalid 1 cycle later, ready=1
//   -> exactly 4 reads at 0x1000, 0x1008, 0x1010, 0x1018; then DONE, mem_req_o=0.
// - FIFO_DEPTH=16, ready=0, frame 64 words
//   -> level_o reaches 16 and holds, with no 17th request; ready=1 resumes fetching.
// - 3 reads outstanding (rvalid delayed 5 cycles) when frame_start_i pulses
//   -> 3 beats dropped, FIFO empty, next request addr = base_addr_i.
// - Rdata pattern = address; ready toggled randomly
//   -> pixel_data_o sequence equals 0x1000, 0x1008, ... in order with no loss or duplicate.
// - en_i=0 in FETCH -> IDLE, mem_req_o=0 next cycle, pixel_valid_o=0, level_o=0.
// - With VGALCD_FETCH_UNDERFLOW_EN: stall gnt 20 cycles with ready=1
//   -> underflow_o=1 and held; frame_start_i clears it. Without the macro it stays 0.

Source files
------------

// File: rtl/vgalcd_fetch.sv
// vgalcd_fetch -- framebuffer fetch stage feeding the vgalcd core pixel port.
//
// Reads the framebuffer as a stream of single-beat 64-bit words starting at
// base_addr_i and buffers them in a first-word-fall-through FIFO. Each word
// carries four 16bpp pixels, with pixel0 in [15:0]. Fetching restarts from
// the base on every frame_start_i pulse. Data still in flight from the
// previous frame is discarded when it returns.
//
// Ports
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   en_i                  fetch enable; low flushes everything and idles
//   base_addr_i           framebuffer base address, 8-byte aligned
//   hvlen_i, vvlen_i      active pixels per line / active lines per frame
//   frame_start_i         one-cycle restart pulse (core vend_o)
//   mem_req_o/addr_o      read request and address (held until granted)
//   mem_gnt_i             request accepted
//   mem_rvalid_i/rdata_i  in-order read data, one beat per grant
//   pixel_valid_o/ready_i/data_o  FWFT pixel word handshake
//   level_o               FIFO occupancy
//   underflow_o           sticky underflow flag (optional feature)
//
// Build option
//   VGALCD_FETCH_UNDERFLOW_EN  enables underflow_o and the 16-bit saturating
//                              event counter s_ufl_cnt_q. When undefined,
//                              underflow_o is tied to 0.

`ifndef VGALCD_VB_WIDTH
`define VGALCD_VB_WIDTH 16
`endif

module vgalcd_fetch #(
   parameter int FIFO_DEPTH = 16,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                            clk_i,
   input  logic                            rst_n_i,
   input  logic                            en_i,
   input  logic [ADDR_WIDTH-1:0]           base_addr_i,
   input  logic [`VGALCD_VB_WIDTH-1:0]     hvlen_i,
   input  logic [`VGALCD_VB_WIDTH-1:0]     vvlen_i,
   input  logic                            frame_start_i,
   output logic                            mem_req_o,
   output logic [ADDR_WIDTH-1:0]           mem_addr_o,
   input  logic                            mem_gnt_i,
   input  logic                            mem_rvalid_i,
   input  logic [63:0]                     mem_rdata_i,
   output logic                            pixel_valid_o,
   input  logic                            pixel_ready_i,
   output logic [63:0]                     pixel_data_o,
   output logic [$clog2(FIFO_DEPTH):0]     level_o,
   output logic                            underflow_o
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]            r_state;
   logic [31:0]           r_frame_words;
   logic [31:0]           r_issued;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [LW-1:0]         r_out;      // all beats in flight, including ones to drop
   logic [LW-1:0]         r_drop;     // beats still to be discarded on return
   logic [63:0]           r_fifo [FIFO_DEPTH];
   logic [LW-1:0]         r_wptr;
   logic [LW-1:0]         r_rptr;

   logic                  w_restart;
   logic                  w_flush;
   logic [LW-1:0]         w_level;
   logic                  w_credit;
   logic                  w_req;
   logic                  w_grant;
   logic [LW-1:0]         w_out_nxt;
   logic                  w_wr;
   logic                  w_rd;
   logic                  w_valid;
   logic [31:0]           w_prod;

   assign w_restart = frame_start_i & en_i;
   assign w_flush   = w_restart | ~en_i;
   assign w_level   = r_wptr - r_rptr;
   assign w_prod    = 32'(hvlen_i) * 32'(vvlen_i);

   // Credit is built from registered state only, so pixel_ready_i never
   // reaches mem_req_o combinationally. Counting every in-flight beat
   // (dropped or not) keeps the FIFO from ever overflowing.
   assign w_credit  = ({1'b0, w_level} + {1'b0, r_out}) < (LW+1)'(FIFO_DEPTH);
   assign w_req     = (r_state == S_FETCH) && (r_issued < r_frame_words) && w_credit;
   assign w_grant   = w_req & mem_gnt_i;
   assign w_out_nxt = r_out + LW'(w_grant) - LW'(mem_rvalid_i);

   assign w_valid   = (w_level != '0) && (r_drop == '0);
   assign w_rd      = w_valid & pixel_ready_i;
   assign w_wr      = mem_rvalid_i && (r_drop == '0) && !w_flush;

   assign mem_req_o     = w_req;
   assign mem_addr_o    = r_addr;
   assign pixel_valid_o = w_valid;
   assign pixel_data_o  = r_fifo[r_rptr[PW-1:0]];
   assign level_o       = w_level;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state       <= S_IDLE;
         r_frame_words <= '0;
         r_issued      <= '0;
         r_addr        <= '0;
         r_out         <= '0;
         r_drop        <= '0;
         r_wptr        <= '0;
         r_rptr        <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
      end else begin
         if (!en_i)
            r_state <= S_IDLE;
         else if (w_restart)
            r_state <= S_FETCH;
         else if ((r_state == S_FETCH) && (r_issued >= r_frame_words))
            r_state <= S_DONE;

         if (w_restart) begin
            r_frame_words <= w_prod >> 2;
            r_issued      <= '0;
            r_addr        <= base_addr_i;
         end else if (w_grant) begin
            r_issued      <= r_issued + 32'd1;
            r_addr        <= r_addr + ADDR_WIDTH'(8);
         end

         r_out <= w_out_nxt;

         // On a flush everything still in flight (including a grant taken
         // this very cycle) belongs to the abandoned frame.
         if (w_flush)
            r_drop <= w_out_nxt;
         else if (mem_rvalid_i && (r_drop != '0))
            r_drop <= r_drop - LW'(1);

         if (w_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
         end else begin
            if (w_wr) begin
               r_fifo[r_wptr[PW-1:0]] <= mem_rdata_i;
               r_wptr <= r_wptr + LW'(1);
            end
            if (w_rd) r_rptr <= r_rptr + LW'(1);
         end
      end
   end

`ifdef VGALCD_FETCH_UNDERFLOW_EN
   logic        r_ufl;
   logic [15:0] s_ufl_cnt_q;
   logic        w_ufl_evt;

   // Core wants a word, none is available, and the frame has started fetching.
   assign w_ufl_evt = pixel_ready_i && !w_valid && (r_state == S_FETCH) && (r_issued != '0);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_ufl       <= 1'b0;
         s_ufl_cnt_q <= '0;
      end else begin
         if (w_flush)
            r_ufl <= 1'b0;
         else if (w_ufl_evt)
            r_ufl <= 1'b1;
         if (w_ufl_evt && (s_ufl_cnt_q != 16'hFFFF))
            s_ufl_cnt_q <= s_ufl_cnt_q + 16'd1;
      end
   end

   assign underflow_o = r_ufl;
`else
   assign underflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_vgalcd_fetch.sv
`ifndef VGALCD_VB_WIDTH
`define VGALCD_VB_WIDTH 16
`endif

module tb_vgalcd_fetch;
   localparam int DEPTH = 16;
   localparam int AW    = 32;
   localparam int LW    = 5;
`ifdef VGALCD_FETCH_UNDERFLOW_EN
   localparam logic UFL_EXP = 1'b1;
`else
   localparam logic UFL_EXP = 1'b0;
`endif

   logic                        clk_i = 0;
   logic                        rst_n_i = 0;
   logic                        en_i = 0;
   logic [AW-1:0]               base_addr_i = '0;
   logic [`VGALCD_VB_WIDTH-1:0] hvlen_i = '0;
   logic [`VGALCD_VB_WIDTH-1:0] vvlen_i = '0;
   logic                        frame_start_i = 0;
   logic                        mem_req_o;
   logic [AW-1:0]               mem_addr_o;
   logic                        mem_gnt_i = 0;
   logic                        mem_rvalid_i = 0;
   logic [63:0]                 mem_rdata_i = '0;
   logic                        pixel_valid_o;
   logic                        pixel_ready_i = 0;
   logic [63:0]                 pixel_data_o;
   logic [LW-1:0]               level_o;
   logic                        underflow_o;

   vgalcd_fetch #(.FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .base_addr_i(base_addr_i),
      .hvlen_i(hvlen_i), .vvlen_i(vvlen_i), .frame_start_i(frame_start_i),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .pixel_valid_o(pixel_valid_o), .pixel_ready_i(pixel_ready_i),
      .pixel_data_o(pixel_data_o), .level_o(level_o), .underflow_o(underflow_o));

   always #5 clk_i = ~clk_i;

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Memory / consumer model knobs (written by the main flow at posedge+2).
   int   lat = 1;
   bit   gnt_rand = 0;
   bit   gnt_stall = 0;
   bit   rdy_rand = 0;
   bit   rdy = 0;

   logic [31:0] pend_addr[$];
   int          pend_due[$];
   logic [31:0] glog[$];
   logic [63:0] plog[$];
   int          cyc = 0;
   int          last_due = 0;
   int          mem_d;
   int          ovf = 0;

   // Decides what happens at the following posedge: grant, read beat, ready.
   always @(negedge clk_i) begin
      cyc++;
      if (!rst_n_i) begin
         mem_gnt_i = 0; mem_rvalid_i = 0; pixel_ready_i = 0;
      end else begin
         if (level_o > LW'(DEPTH)) ovf++;
         mem_gnt_i = gnt_stall ? 1'b0 : (gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1);
         if (mem_req_o && mem_gnt_i) begin
            mem_d = cyc + lat;
            if (mem_d <= last_due) mem_d = last_due + 1;
            last_due = mem_d;
            pend_addr.push_back(mem_addr_o);
            pend_due.push_back(mem_d);
            glog.push_back(mem_addr_o);
         end
         if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            mem_rvalid_i = 1;
            mem_rdata_i  = {32'h0, pend_addr.pop_front()};
            void'(pend_due.pop_front());
         end else begin
            mem_rvalid_i = 0;
            mem_rdata_i  = {$urandom, $urandom};
         end
         pixel_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : rdy;
         if (pixel_valid_o && pixel_ready_i) plog.push_back(pixel_data_o);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk_i);
      #2;
   endtask

   // Caller is at posedge+2; logs are cleared after the restart edge so they
   // only hold traffic of the new frame.
   task automatic pulse_start();
      frame_start_i = 1;
      step(1);
      frame_start_i = 0;
      glog.delete();
      plog.delete();
   endtask

   task automatic idle_gap();
      en_i = 0;
      step(12);
      en_i = 1;
      step(1);
   endtask

   task automatic wait_pix(input int n, input int maxc);
      int c = 0;
      while (plog.size() < n && c < maxc) begin
         step(1);
         c++;
      end
   endtask

   // Reference: a frame is the word stream base, base+8, ... (mod 2^32),
   // frame_words = hvlen*vvlen/4 long, delivered in order exactly once.
   task automatic check_frame(input string nm, input logic [31:0] base, input int n, input bit chk_g);
      int bad = 0;
      logic [31:0] a;
      check({nm, "_npix"}, 64'(plog.size()), 64'(n));
      for (int k = 0; k < plog.size() && k < n; k++) begin
         a = base + 32'(8 * k);
         if (plog[k] !== {32'h0, a}) bad++;
      end
      check({nm, "_pixbad"}, 64'(bad), 64'd0);
      if (chk_g) begin
         bad = 0;
         check({nm, "_ngnt"}, 64'(glog.size()), 64'(n));
         for (int k = 0; k < glog.size() && k < n; k++) begin
            a = base + 32'(8 * k);
            if (glog[k] !== a) bad++;
         end
         check({nm, "_gntbad"}, 64'(bad), 64'd0);
      end
   endtask

   typedef struct {
      logic [15:0] h;
      logic [15:0] v;
      logic [31:0] base;
      int          words;
   } vec_t;

   vec_t tbl[5];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{h: 16'd8,  v: 16'd2, base: 32'h0000_1000, words: 4};
      tbl[1] = '{h: 16'd0,  v: 16'd5, base: 32'h0000_2000, words: 0};
      tbl[2] = '{h: 16'd4,  v: 16'd1, base: 32'h0000_3000, words: 1};
      tbl[3] = '{h: 16'd16, v: 16'd4, base: 32'hFFFF_FFF0, words: 16};
      tbl[4] = '{h: 16'd12, v: 16'd3, base: 32'h0000_4008, words: 9};

      // Reset state
      step(3);
      check("rst_req",   64'(mem_req_o), 0);
      check("rst_addr",  64'(mem_addr_o), 0);
      check("rst_valid", 64'(pixel_valid_o), 0);
      check("rst_data",  pixel_data_o, 0);
      check("rst_level", 64'(level_o), 0);
      check("rst_ufl",   64'(underflow_o), 0);
      rst_n_i = 1;
      step(2);

      // Table-driven frames: full-rate memory and consumer
      lat = 1; gnt_rand = 0; rdy_rand = 0; rdy = 1;
      foreach (tbl[i]) begin
         idle_gap();
         hvlen_i = tbl[i].h; vvlen_i = tbl[i].v; base_addr_i = tbl[i].base;
         pulse_start();
         wait_pix(tbl[i].words, 300);
         step(6);
         check_frame($sformatf("tbl%0d", i), tbl[i].base, tbl[i].words, 1);
         check($sformatf("tbl%0d_req_done", i), 64'(mem_req_o), 0);
      end

      // Backpressure: FIFO fills to depth, no extra request, then resumes
      idle_gap();
      rdy = 0; hvlen_i = 16; vvlen_i = 16; base_addr_i = 32'h5000;
      pulse_start();
      step(40);
      check("bp_level", 64'(level_o), DEPTH);
      check("bp_ngnt",  64'(glog.size()), DEPTH);
      check("bp_req",   64'(mem_req_o), 0);
      check("bp_valid", 64'(pixel_valid_o), 1);
      check("bp_head",  pixel_data_o, 64'h5000);
      rdy = 1;
      wait_pix(64, 600);
      step(6);
      check_frame("bp", 32'h5000, 64, 1);

      // Restart with 3 reads in flight
      idle_gap();
      rdy = 0; lat = 6; hvlen_i = 16; vvlen_i = 16; base_addr_i = 32'h8000;
      pulse_start();
      step(2);
      hvlen_i = 8; vvlen_i = 2; base_addr_i = 32'h1000;
      pulse_start();
      check("drop_valid", 64'(pixel_valid_o), 0);
      check("drop_level", 64'(level_o), 0);
      check("drop_addr",  64'(mem_addr_o), 64'h1000);
      step(8);
      check("drop_valid2", 64'(pixel_valid_o), 1);
      check("drop_head",   pixel_data_o, 64'h1000);
      rdy = 1;
      wait_pix(4, 200);
      step(10);
      check_frame("drop", 32'h1000, 4, 1);

      // Disable mid-fetch, then a frame_start while disabled is ignored
      idle_gap();
      lat = 3; rdy = 0; hvlen_i = 16; vvlen_i = 16; base_addr_i = 32'h6000;
      pulse_start();
      step(6);
      en_i = 0;
      step(1);
      check("dis_req",   64'(mem_req_o), 0);
      check("dis_valid", 64'(pixel_valid_o), 0);
      check("dis_level", 64'(level_o), 0);
      pulse_start();
      step(10);
      check("dis_ign_gnt", 64'(glog.size()), 0);
      check("dis_ign_req", 64'(mem_req_o), 0);
      en_i = 1;
      step(1);

      // Underflow: grant stall while the consumer keeps asking
      idle_gap();
      lat = 1; rdy = 1; hvlen_i = 16; vvlen_i = 16; base_addr_i = 32'h7000;
      pulse_start();
      step(4);
      gnt_stall = 1;
      step(20);
      check("ufl_set",  64'(underflow_o), 64'(UFL_EXP));
      step(5);
      check("ufl_hold", 64'(underflow_o), 64'(UFL_EXP));
      pulse_start();
      check("ufl_clr",  64'(underflow_o), 0);
      gnt_stall = 0;

      // Randomized frames: random grant, ready and latency
      gnt_rand = 1; rdy_rand = 1;
      for (int it = 0; it < 6; it++) begin
         int n;
         idle_gap();
         lat = $urandom_range(1, 4);
         hvlen_i = 16'(4 * $urandom_range(1, 10));
         vvlen_i = 16'($urandom_range(1, 8));
         base_addr_i = {$urandom, 3'b000} & 32'hFFFF_FFF8;
         n = (int'(hvlen_i) * int'(vvlen_i)) / 4;
         pulse_start();
         wait_pix(n, 3000);
         step(12);
         check_frame($sformatf("rnd%0d", it), base_addr_i, n, 1);
      end
      check("no_overflow", 64'(ovf), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
